// File: rtl/xor_logic_pipe.sv
// xor_logic_pipe: selectable bitwise op unit (with XOR accumulator) feeding a
// STAGES-deep elastic valid/ready pipeline and an output transfer counter.
module xor_logic_pipe #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned STAGES = 2,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] acc,
   output logic [CNT_W-1:0] tx_count
);

   localparam logic [2:0] OP_XOR  = 3'd0;
   localparam logic [2:0] OP_AND  = 3'd1;
   localparam logic [2:0] OP_OR   = 3'd2;
   localparam logic [2:0] OP_XNOR = 3'd3;
   localparam logic [2:0] OP_NAND = 3'd4;
   localparam logic [2:0] OP_NOR  = 3'd5;
   localparam logic [2:0] OP_ACCX = 3'd6;
   localparam logic [2:0] OP_ACCC = 3'd7;

   logic [STAGES-1:0] rdy;
   logic [STAGES-1:0] vld;
   logic [WIDTH-1:0]  data [STAGES];
   logic [WIDTH-1:0]  res;
   logic [WIDTH-1:0]  acc_nxt;
   logic              rdy_chain;
   logic              in_fire;
   logic              out_fire;

   // Ready chain: a stage can take a beat if it is empty or its beat moves on
   always_comb begin
      rdy       = '0;
      rdy_chain = out_ready;
      for (int i = int'(STAGES) - 1; i >= 0; i--) begin
         rdy_chain = !vld[i] || rdy_chain;
         rdy[i]    = rdy_chain;
      end
   end

   assign in_ready  = rdy[0];
   assign in_fire   = in_valid && rdy[0];
   assign out_valid = vld[STAGES-1];
   assign y         = data[STAGES-1];
   assign out_fire  = vld[STAGES-1] && out_ready;

   // Operation select and next accumulator value for the incoming beat
   always_comb begin
      res     = '0;
      acc_nxt = acc;
      case (op)
         OP_XOR:  res = a ^ b;
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XNOR: res = ~(a ^ b);
         OP_NAND: res = ~(a & b);
         OP_NOR:  res = ~(a | b);
         OP_ACCX: begin
            acc_nxt = acc ^ a ^ b;
            res     = acc ^ a ^ b;
         end
         OP_ACCC: begin
            acc_nxt = '0;
            res     = '0;
         end
         default: res = '0;
      endcase
   end

   // Pipeline stages: stage 0 takes new beats, later stages take from upstream
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld <= '0;
         for (int i = 0; i < int'(STAGES); i++) begin
            data[i] <= '0;
         end
      end else begin
         if (rdy[0]) begin
            vld[0] <= in_valid;
            if (in_valid) begin
               data[0] <= res;
            end
         end
         for (int i = 1; i < int'(STAGES); i++) begin
            if (rdy[i]) begin
               vld[i] <= vld[i-1];
               if (vld[i-1]) begin
                  data[i] <= data[i-1];
               end
            end
         end
      end
   end

   // Accumulator only moves on an accepted beat
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
      end else if (in_fire) begin
         acc <= acc_nxt;
      end
   end

   // Output transfer counter, wraps naturally
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_count <= '0;
      end else if (out_fire) begin
         tx_count <= tx_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_xor_logic_pipe.sv
// Directed and randomised self-checking bench for xor_logic_pipe.
module tb_xor_logic_pipe;

   localparam int unsigned W  = 4;
   localparam int unsigned S  = 2;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [2:0]    op;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  y;
   logic [W-1:0]  acc;
   logic [CW-1:0] tx_count;

   int checks   = 0;
   int failures = 0;
   int exp_tx   = 0;

   xor_logic_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .acc(acc), .tx_count(tx_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic [2:0] mop, inout logic [W-1:0] macc);
      logic [W-1:0] r;
      case (mop)
         3'd0: r = ma ^ mb;
         3'd1: r = ma & mb;
         3'd2: r = ma | mb;
         3'd3: r = ~(ma ^ mb);
         3'd4: r = ~(ma & mb);
         3'd5: r = ~(ma | mb);
         3'd6: begin macc = macc ^ ma ^ mb; r = macc; end
         default: begin macc = '0; r = '0; end
      endcase
      return r;
   endfunction

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; a = 4'hA; b = 4'h6; op = 3'd0; out_ready = 1'b1;
      #2 reset = 1'b0;
      step(); step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (y !== 4'h0) begin failures++; $display("FAIL reset_y got=%h exp=0", y); end
      checks++; if (acc !== 4'h0) begin failures++; $display("FAIL reset_acc got=%h exp=0", acc); end
      checks++; if (tx_count !== 4'h0) begin failures++; $display("FAIL reset_tx got=%0d exp=0", tx_count); end
      reset = 1'b1; in_valid = 1'b0;
      step(); step(); step();
      checks++; if (tx_count !== 4'h0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_release got tx=%0d ov=%b exp tx=0 ov=0", tx_count, out_valid);
      end
      exp_tx = 0;
   endtask

   task automatic test_op_sweep();
      logic [W-1:0] expv [6];
      expv[0] = 4'hC; expv[1] = 4'h2; expv[2] = 4'hE;
      expv[3] = 4'h3; expv[4] = 4'hD; expv[5] = 4'h1;
      a = 4'hA; b = 4'h6; out_ready = 1'b1; in_valid = 1'b1;
      for (int j = 0; j < 6; j++) begin
         op = 3'(j);
         step();
         if (j >= 1) begin
            checks++;
            if (out_valid !== 1'b1 || y !== expv[j-1]) begin
               failures++; $display("FAIL op_sweep_%0d got y=%h ov=%b exp y=%h ov=1", j-1, y, out_valid, expv[j-1]);
            end
         end
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1 || y !== expv[5]) begin
         failures++; $display("FAIL op_sweep_5 got y=%h ov=%b exp y=%h ov=1", y, out_valid, expv[5]);
      end
      step();
      exp_tx += 6;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL op_sweep_drain got ov=%b exp=0", out_valid); end
      checks++; if (tx_count !== CW'(exp_tx)) begin failures++; $display("FAIL op_sweep_tx got=%0d exp=%0d", tx_count, CW'(exp_tx)); end
   endtask

   task automatic test_accumulator();
      logic [2:0]   ops [5];
      logic [W-1:0] as  [5];
      logic [W-1:0] bs  [5];
      logic [W-1:0] ey  [5];
      logic [W-1:0] ea  [5];
      ops[0] = 3'd7; as[0] = 4'h0; bs[0] = 4'h0; ey[0] = 4'h0; ea[0] = 4'h0;
      ops[1] = 3'd6; as[1] = 4'h3; bs[1] = 4'h0; ey[1] = 4'h3; ea[1] = 4'h3;
      ops[2] = 3'd0; as[2] = 4'hF; bs[2] = 4'hF; ey[2] = 4'h0; ea[2] = 4'h3;
      ops[3] = 3'd6; as[3] = 4'h5; bs[3] = 4'h0; ey[3] = 4'h6; ea[3] = 4'h6;
      ops[4] = 3'd6; as[4] = 4'h0; bs[4] = 4'hF; ey[4] = 4'h9; ea[4] = 4'h9;
      out_ready = 1'b1; in_valid = 1'b1;
      for (int j = 0; j < 5; j++) begin
         op = ops[j]; a = as[j]; b = bs[j];
         step();
         checks++; if (acc !== ea[j]) begin failures++; $display("FAIL acc_%0d got=%h exp=%h", j, acc, ea[j]); end
         if (j >= 1) begin
            checks++; if (out_valid !== 1'b1 || y !== ey[j-1]) begin
               failures++; $display("FAIL acc_y_%0d got y=%h ov=%b exp y=%h", j-1, y, out_valid, ey[j-1]);
            end
         end
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1 || y !== ey[4]) begin
         failures++; $display("FAIL acc_y_4 got y=%h ov=%b exp y=%h", y, out_valid, ey[4]);
      end
      step();
      exp_tx += 5;
      checks++; if (acc !== 4'h9) begin failures++; $display("FAIL acc_final got=%h exp=9", acc); end
      checks++; if (tx_count !== CW'(exp_tx)) begin failures++; $display("FAIL acc_tx got=%0d exp=%0d", tx_count, CW'(exp_tx)); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; op = 3'd0;
      in_valid = 1'b1; a = 4'h1; b = 4'h4;
      step();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++; $display("FAIL bp_first got rdy=%b ov=%b exp rdy=1 ov=0", in_ready, out_valid);
      end
      a = 4'h2; b = 4'h8;
      step();
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 4'h5) begin
         failures++; $display("FAIL bp_full got rdy=%b ov=%b y=%h exp rdy=0 ov=1 y=5", in_ready, out_valid, y);
      end
      a = 4'h7; b = 4'h1;
      step(); step();
      checks++; if (in_ready !== 1'b0 || y !== 4'h5 || acc !== 4'h9) begin
         failures++; $display("FAIL bp_hold got rdy=%b y=%h acc=%h exp rdy=0 y=5 acc=9", in_ready, y, acc);
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_rdy got=%b exp=1", in_ready); end
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || y !== 4'hA) begin
         failures++; $display("FAIL bp_drain1 got ov=%b y=%h exp ov=1 y=a", out_valid, y);
      end
      step();
      checks++; if (out_valid !== 1'b1 || y !== 4'h6) begin
         failures++; $display("FAIL bp_drain2 got ov=%b y=%h exp ov=1 y=6", out_valid, y);
      end
      step();
      exp_tx += 3;
      checks++; if (out_valid !== 1'b0 || tx_count !== CW'(exp_tx)) begin
         failures++; $display("FAIL bp_done got ov=%b tx=%0d exp ov=0 tx=%0d", out_valid, tx_count, CW'(exp_tx));
      end
   endtask

   task automatic test_random();
      logic [W-1:0] expq [$];
      logic [W-1:0] macc;
      logic [W-1:0] r;
      logic         exp_rdy;
      logic         hold;
      int           accepted;
      int           drained;
      int           cycles;
      int           bad;
      macc = 4'h9; hold = 1'b0; accepted = 0; drained = 0; cycles = 0; bad = 0;
      in_valid = 1'b0;
      while (accepted < 1000 && cycles < 20000) begin
         step();
         cycles++;
         if (!hold) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 4'($urandom); b = 4'($urandom); op = 3'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         exp_rdy = (expq.size() < int'(S)) || out_ready;
         checks++; if (in_ready !== exp_rdy) begin
            failures++; bad++;
            if (bad < 10) $display("FAIL rnd_in_ready got=%b exp=%b cyc=%0d", in_ready, exp_rdy, cycles);
         end
         checks++; if (out_valid === 1'b1 && expq.size() == 0) begin
            failures++; bad++;
            if (bad < 10) $display("FAIL rnd_spurious_valid got ov=1 exp ov=0 cyc=%0d", cycles);
         end
         if (out_valid === 1'b1 && out_ready && expq.size() > 0) begin
            checks++; if (y !== expq[0]) begin
               failures++; bad++;
               if (bad < 10) $display("FAIL rnd_y got=%h exp=%h beat=%0d", y, expq[0], drained);
            end
            void'(expq.pop_front());
            drained++;
         end
         if (in_valid && in_ready === 1'b1) begin
            r = model(a, b, op, macc);
            expq.push_back(r);
            accepted++;
            hold = 1'b0;
         end else begin
            hold = in_valid;
         end
      end
      checks++; if (accepted < 1000) begin
         failures++; $display("FAIL rnd_timeout got accepted=%0d exp=1000", accepted);
      end
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      cycles = 0;
      while (expq.size() > 0 && cycles < 20) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            checks++; if (y !== expq[0]) begin
               failures++; $display("FAIL rnd_drain_y got=%h exp=%h", y, expq[0]);
            end
            void'(expq.pop_front());
            drained++;
         end
         step();
         cycles++;
      end
      checks++; if (expq.size() != 0) begin
         failures++; $display("FAIL rnd_drain_timeout got left=%0d exp=0", expq.size());
      end
      exp_tx += drained;
      checks++; if (tx_count !== CW'(exp_tx)) begin
         failures++; $display("FAIL rnd_tx got=%0d exp=%0d", tx_count, CW'(exp_tx));
      end
      checks++; if (acc !== macc) begin failures++; $display("FAIL rnd_acc got=%h exp=%h", acc, macc); end
   endtask

   task automatic test_reset_mid_and_wrap();
      step();
      out_ready = 1'b0; in_valid = 1'b1; op = 3'd6; a = 4'h5; b = 4'h2;
      step(); step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_inflight got ov=%b exp=1", out_valid); end
      reset = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || acc !== 4'h0 || tx_count !== 4'h0 || y !== 4'h0) begin
         failures++; $display("FAIL mid_reset got ov=%b acc=%h tx=%0d y=%h exp all 0", out_valid, acc, tx_count, y);
      end
      step();
      reset = 1'b1; out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_flushed got ov=%b exp=0", out_valid); end
      in_valid = 1'b1; op = 3'd0; a = 4'h3; b = 4'h3;
      for (int j = 0; j < 17; j++) step();
      in_valid = 1'b0;
      step(); step(); step();
      checks++; if (tx_count !== 4'd1) begin failures++; $display("FAIL wrap_tx got=%0d exp=1", tx_count); end
   endtask

   initial begin
      test_reset();
      test_op_sweep();
      test_accumulator();
      test_backpressure();
      test_random();
      test_reset_mid_and_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xor_logic_pipe.md
Name: xor_logic_pipe

Overview:
Parametrised successor to the single-cycle 4-bit registered XOR unit. Computes a selectable bitwise operation on two WIDTH-bit operands, including an accumulating XOR mode. Carries results through a STAGES-deep elastic pipeline with valid/ready handshakes, and counts completed output transfers. Sits between an operand source and a result consumer in the logic-datapath test environment.

Parameters:
WIDTH, 4, operand/result width in bits (>=1)
STAGES, 2, pipeline register stages = latency in cycles (>=1)
CNT_W, 16, width of the output transfer counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous active-low reset (0 = reset asserted)
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  operation select, sampled with the beat
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
y  output  WIDTH  result
acc  output  WIDTH  current accumulator value
tx_count  output  CNT_W  number of completed output transfers

Behaviour:
- Reset (reset=0, async): all stage valid bits=0, all stage data=0, acc=0, tx_count=0. Hence out_valid=0, y=0. Release is synchronous to clk and takes effect on the first rising edge with reset=1.
- Handshake: a transfer occurs when valid&&ready are both 1 on a rising edge. Producers hold data stable while valid=1 and ready=0.
- Ready chain (combinational):
  - rdy[STAGES]=out_ready
  - rdy[i] = !vld[i] || rdy[i+1]
  - in_ready = rdy[0]
  - Bubbles collapse. No combinational path from a/b/op to y.
- Stage 0 loads on an input transfer; stage i>0 loads from stage i-1 when rdy[i]=1. A stage whose upstream has no valid beat, and whose own beat leaves, clears its valid bit.
- Result is computed at input acceptance (stage 0 load):
  - op 0: a^b
  - op 1: a&b
  - op 2: a|b
  - op 3: ~(a^b)
  - op 4: ~(a&b)
  - op 5: ~(a|b)
  - op 6 ACC_XOR: acc_next = acc^a^b; result = acc_next; acc <= acc_next
  - op 7 ACC_CLR: acc <= 0; result = 0
- acc changes only on an input transfer with op 6/7; all other ops leave acc unchanged.
- Latency: a beat accepted at edge k appears on y/out_valid after edge k+STAGES-1, when no stall occurs. Full throughput is 1 beat/cycle while out_ready=1.
- Stall: out_ready=0 with the pipeline full gives in_ready=0, and y, out_valid and acc hold. When out_ready=0 but bubbles exist, new beats still enter up to STAGES total.
- Capacity: exactly STAGES beats in flight; no loss and no duplication.
- tx_count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Simultaneous output and input transfer in the same cycle with a full pipeline is legal: in_ready=1 when out_ready=1.
- Reset mid-operation: in-flight beats are discarded, acc and tx_count clear, and out_valid drops immediately (async).
- Width rule: all ops are bitwise on WIDTH bits; there is no carry or extension.

Test Plan:
1. Reset check: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, y=0, acc=0, tx_count=0, and no transfer counted after release until a valid beat enters.
2. Op sweep: WIDTH=4, STAGES=2, out_ready=1, a=4'hA, b=4'h6, with op 0..5 on consecutive cycles -> y = 4'hC, 4'h2, 4'hE, 4'h3, 4'hD, 4'h1. Each appears 2 edges after acceptance, back-to-back; tx_count=6.
3. Accumulator: op7, then op6(a=3,b=0), op6(a=5,b=0), op6(a=0,b=F) -> y = 0, 3, 6, 9; acc ends 9. An interleaved op0 beat leaves acc unchanged.
4. Backpressure: out_ready=0 and 3 beats offered -> in_ready drops after 2 accepted and y holds the first result. Raising out_ready drains results in order, the third beat is accepted on the first drain cycle, and no beat is lost or duplicated.
5. Random vs model: 1000 random a/b/op beats with random in_valid/out_ready -> every y matches the reference model in order, and tx_count equals the number of beats drained.
6. Mid-flight reset and wrap: assert reset with 2 beats in flight -> out_valid=0 immediately, acc=0. Then with CNT_W=4, 17 transfers -> tx_count=1.
